// File: rtl/edge_event_arbiter_pkg.sv
// Shared types for the edge event arbiter.
// edge_pol_t   : polarity of a reported edge (EDGE_FALL=0, EDGE_RISE=1).
// edge_event_t : {channel, polarity}, used for the pending entries and the
//                output slot; the channel field is wide enough for N_MAX.
package edge_event_pkg;

    localparam int N_MAX = 16;
    localparam int CH_W  = $clog2(N_MAX);

    typedef enum logic {
        EDGE_FALL = 1'b0,
        EDGE_RISE = 1'b1
    } edge_pol_t;

    typedef struct packed {
        logic [CH_W-1:0] channel;
        edge_pol_t       polarity;
    } edge_event_t;

endpackage

// File: rtl/edge_event_arbiter_detector.sv
// Single-line edge detector.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset, clears the sample history
//   line : monitored line (already synchronous to clk)
//   rise : one-cycle pulse after a 0->1 transition has been sampled
//   fall : one-cycle pulse after a 1->0 transition has been sampled
// Both history flops reset to 0, so a line held high across reset release
// produces one rising pulse.
module edge_event_arbiter_detector (
    input  logic clk,
    input  logic rst,
    input  logic line,
    output logic rise,
    output logic fall
);

    logic cur;
    logic prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            cur  <= 1'b0;
            prev <= 1'b0;
        end else begin
            cur  <= line;
            prev <= cur;
        end
    end

    assign rise = cur & ~prev;
    assign fall = ~cur & prev;

endmodule

// File: rtl/edge_event_arbiter.sv
// Edge event arbiter: collects rising/falling edge events from N lines,
// buffers one pending event per channel and streams them one at a time over
// a valid/ready interface with round-robin fairness.
// Ports:
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_in[N]             : monitored lines
//   i_pos_en, i_neg_en  : per-channel rising / falling event enables
//   o_valid, i_ready    : output handshake
//   o_channel, o_polarity : reported event (1 = rising)
//   o_lost[N]           : sticky per-channel drop flags
//   i_clear             : clears o_lost (a new drop in the same cycle wins)
// Build option: define EDGE_EVENT_ARBITER_SYNC_EN to insert a 2-flop
// synchronizer per line ahead of its detector (latency 2 -> 4 cycles).
module edge_event_arbiter
    import edge_event_pkg::*;
#(
    parameter  int N  = 4,
    localparam int CW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [N-1:0]  i_in,
    input  logic [N-1:0]  i_pos_en,
    input  logic [N-1:0]  i_neg_en,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [CW-1:0] o_channel,
    output logic          o_polarity,
    output logic [N-1:0]  o_lost,
    input  logic          i_clear
);

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    logic [N-1:0]  rise;
    logic [N-1:0]  fall;
    logic [N-1:0]  qual;
    logic [N-1:0]  pend_v;
    edge_event_t   pend_ev [N];
    logic [N-1:0]  lost;
    logic [N-1:0]  lost_set;
    logic [N-1:0]  leaving;

    slot_state_t   state;
    edge_event_t   slot;
    logic [CW-1:0] ptr;

    logic          found;
    logic [CW-1:0] pick;
    logic          load;

    // First requesting channel after 'last', wrapping modulo N.
    function automatic logic [CW:0] rr_pick(input logic [N-1:0]  req,
                                            input logic [CW-1:0] last);
        logic          hit;
        logic [CW-1:0] idx;
        int unsigned   c;
        hit = 1'b0;
        idx = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            c = (32'(last) + k) % N;
            if (!hit && req[c]) begin
                hit = 1'b1;
                idx = CW'(c);
            end
        end
        return {hit, idx};
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_ch
        logic line;
`ifdef EDGE_EVENT_ARBITER_SYNC_EN
        logic [1:0] sync;
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                sync <= '0;
            end else begin
                sync <= {sync[0], i_in[g]};
            end
        end
        assign line = sync[1];
`else
        assign line = i_in[g];
`endif
        edge_event_arbiter_detector u_det (
            .clk  (i_clk),
            .rst  (i_rst),
            .line (line),
            .rise (rise[g]),
            .fall (fall[g])
        );
    end

    // Masks act only on the pulse itself; stored entries ignore later changes.
    assign qual = (rise & i_pos_en) | (fall & i_neg_en);

    always_comb begin
        {found, pick} = rr_pick(pend_v, ptr);
        load          = found & ((state == SLOT_EMPTY) | i_ready);
        leaving       = '0;
        if (load) begin
            leaving = {{(N-1){1'b0}}, 1'b1} << pick;
        end
        // An entry moving into the slot this cycle frees room for a new event.
        lost_set = qual & pend_v & ~leaving;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pend_v <= '0;
            lost   <= '0;
            for (int unsigned c = 0; c < N; c++) begin
                pend_ev[c] <= '0;
            end
        end else begin
            for (int unsigned c = 0; c < N; c++) begin
                if (leaving[c] || (qual[c] && !pend_v[c])) begin
                    pend_v[c]  <= qual[c];
                    pend_ev[c] <= '{channel: CH_W'(c), polarity: edge_pol_t'(rise[c])};
                end
            end
            lost <= lost_set | (lost & ~{N{i_clear}});
        end
    end

    // Output slot; refilled in the handshake cycle so events stream back to back.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= SLOT_EMPTY;
            slot  <= '0;
            ptr   <= CW'(N - 1);
        end else begin
            case (state)
                SLOT_EMPTY: begin
                    if (found) begin
                        state <= SLOT_FULL;
                        slot  <= pend_ev[pick];
                        ptr   <= pick;
                    end
                end
                SLOT_FULL: begin
                    if (i_ready) begin
                        if (found) begin
                            slot <= pend_ev[pick];
                            ptr  <= pick;
                        end else begin
                            state <= SLOT_EMPTY;
                        end
                    end
                end
                default: state <= SLOT_EMPTY;
            endcase
        end
    end

    assign o_valid    = (state == SLOT_FULL);
    assign o_channel  = CW'(slot.channel);
    assign o_polarity = slot.polarity;
    assign o_lost     = lost;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Self-checking bench for edge_event_arbiter (N=4): a cycle table, directed
// multi-cycle sequences and randomized traffic against a reference model.
module tb_edge_event_arbiter;
    import edge_event_pkg::*;

    localparam int N  = 4;
    localparam int CW = 2;
`ifdef EDGE_EVENT_ARBITER_SYNC_EN
    localparam int EXTRA = 2;
`else
    localparam int EXTRA = 0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  din;
    logic [N-1:0]  pos_en;
    logic [N-1:0]  neg_en;
    logic          valid;
    logic          ready;
    logic [CW-1:0] ch;
    logic          pol;
    logic [N-1:0]  lost;
    logic          clear;

    always #5 clk = ~clk;

    edge_event_arbiter #(.N(N)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_in       (din),
        .i_pos_en   (pos_en),
        .i_neg_en   (neg_en),
        .o_valid    (valid),
        .i_ready    (ready),
        .o_channel  (ch),
        .o_polarity (pol),
        .o_lost     (lost),
        .i_clear    (clear)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int ch;
        bit pol;
        int c;
    } hs_t;
    hs_t hs_log[$];

    typedef struct {
        logic [N-1:0]  din;
        logic          ready;
        logic          clear;
        logic          ev;
        logic [CW-1:0] ech;
        logic          epol;
        logic [N-1:0]  elost;
    } vec_t;
    vec_t tbl[16];

    // Reference model: sampled-line history, one pending slot per channel,
    // an output slot and the index of the last granted channel.
    logic [N-1:0] m_line [EXTRA+2];
    logic [N-1:0] m_pv, m_pp, m_lost;
    logic         m_sv, m_spol;
    logic         m_ok = 1'b0;
    int           m_sch, m_ptr;

    always @(posedge clk) begin : ref_model
        logic [N-1:0] up, dn, q, pv_n, pp_n, set;
        logic hs, found, leave, take;
        int pick, c;
        if (rst) begin
            for (int k = 0; k < EXTRA + 2; k++) m_line[k] <= '0;
            m_pv   <= '0;
            m_pp   <= '0;
            m_lost <= '0;
            m_sv   <= 1'b0;
            m_spol <= 1'b0;
            m_sch  <= 0;
            m_ptr  <= N - 1;
            m_ok   <= 1'b1;
        end else if (m_ok) begin
            up    = m_line[EXTRA] & ~m_line[EXTRA+1];
            dn    = ~m_line[EXTRA] & m_line[EXTRA+1];
            q     = (up & pos_en) | (dn & neg_en);
            hs    = m_sv && ready;
            found = 1'b0;
            pick  = 0;
            for (int k = 1; k <= N; k++) begin
                c = (m_ptr + k) % N;
                if (!found && m_pv[c]) begin
                    found = 1'b1;
                    pick  = c;
                end
            end
            take = found && (!m_sv || hs);
            pv_n = m_pv;
            pp_n = m_pp;
            set  = '0;
            for (int k = 0; k < N; k++) begin
                leave = take && (pick == k);
                if (leave) begin
                    pv_n[k] = q[k];
                    pp_n[k] = up[k];
                end else if (q[k]) begin
                    if (m_pv[k]) set[k] = 1'b1;
                    else begin
                        pv_n[k] = 1'b1;
                        pp_n[k] = up[k];
                    end
                end
            end
            m_pv   <= pv_n;
            m_pp   <= pp_n;
            m_lost <= set | (clear ? '0 : m_lost);
            if (take) begin
                m_sv   <= 1'b1;
                m_sch  <= pick;
                m_spol <= m_pp[pick];
                m_ptr  <= pick;
            end else if (hs) begin
                m_sv <= 1'b0;
            end
            m_line[0] <= din;
            for (int k = 1; k < EXTRA + 2; k++) m_line[k] <= m_line[k-1];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        if (valid && ready && !rst) hs_log.push_back('{ch: int'(ch), pol: pol, c: cyc});
        @(posedge clk);
        #1;
        cyc++;
        if (m_ok) begin
            chk("model_valid", 32'(valid), 32'(m_sv));
            chk("model_lost", 32'(lost), 32'(m_lost));
            if (m_sv) begin
                chk("model_channel", 32'(ch), m_sch);
                chk("model_polarity", 32'(pol), 32'(m_spol));
            end
        end
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        din   = '0;
        ready = 1'b0;
        clear = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin : main
        int first;
        int exp2[4];

        rst    = 1'b1;
        din    = '0;
        pos_en = '1;
        neg_en = '1;
        ready  = 1'b0;
        clear  = 1'b0;
        tick();
        tick();
        chk("reset_valid", 32'(valid), 0);
        chk("reset_channel", 32'(ch), 0);
        chk("reset_polarity", 32'(pol), 0);
        chk("reset_lost", 32'(lost), 0);
        rst = 1'b0;

        // Cycle table (latency-2 timing; lines are fed EXTRA rows early in the sync build).
        tbl[0]  = '{4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000};
        tbl[1]  = '{4'b0100, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000};
        tbl[2]  = '{4'b0100, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000};
        tbl[3]  = '{4'b0100, 1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 4'b0000};
        tbl[4]  = '{4'b0100, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000};
        tbl[5]  = '{4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000};
        tbl[6]  = '{4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000};
        tbl[7]  = '{4'b0000, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 4'b0000};
        tbl[8]  = '{4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000};
        tbl[9]  = '{4'b0010, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000};
        tbl[10] = '{4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000};
        tbl[11] = '{4'b0010, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 4'b0000};
        tbl[12] = '{4'b0010, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 4'b0010};
        tbl[13] = '{4'b0010, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 4'b0000};
        tbl[14] = '{4'b0010, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 4'b0000};
        tbl[15] = '{4'b0010, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000};

        for (int i = -EXTRA; i < 16; i++) begin
            int j, r;
            j     = (i + EXTRA > 15) ? 15 : i + EXTRA;
            r     = (i < 0) ? 0 : i;
            din   = tbl[j].din;
            ready = tbl[r].ready;
            clear = tbl[r].clear;
            tick();
            if (i >= 0) begin
                chk($sformatf("tbl%0d_valid", i), 32'(valid), 32'(tbl[i].ev));
                chk($sformatf("tbl%0d_lost", i), 32'(lost), 32'(tbl[i].elost));
                if (tbl[i].ev) begin
                    chk($sformatf("tbl%0d_channel", i), 32'(ch), 32'(tbl[i].ech));
                    chk($sformatf("tbl%0d_polarity", i), 32'(pol), 32'(tbl[i].epol));
                end
            end
        end

        // Simultaneous bursts: round-robin order and one event per cycle.
        do_reset();
        pos_en = '1;
        neg_en = '0;
        ready  = 1'b1;
        hs_log.delete();
        din = 4'b1111;
        repeat (10) tick();
        chk("burst1_count", hs_log.size(), 4);
        for (int i = 0; i < 4 && i < hs_log.size(); i++) begin
            chk($sformatf("burst1_ch%0d", i), hs_log[i].ch, i);
            if (i > 0) chk($sformatf("burst1_gap%0d", i), hs_log[i].c - hs_log[i-1].c, 1);
        end
        din = 4'b0000;
        repeat (4) tick();
        hs_log.delete();
        din = 4'b0010;
        repeat (6) tick();
        chk("single_ch1_count", hs_log.size(), 1);
        din = 4'b0000;
        repeat (4) tick();
        hs_log.delete();
        din = 4'b1111;
        repeat (10) tick();
        exp2 = '{2, 3, 0, 1};
        chk("burst2_count", hs_log.size(), 4);
        for (int i = 0; i < 4 && i < hs_log.size(); i++) begin
            chk($sformatf("burst2_ch%0d", i), hs_log[i].ch, exp2[i]);
            if (i > 0) chk($sformatf("burst2_gap%0d", i), hs_log[i].c - hs_log[i-1].c, 1);
        end

        // Rising edges masked on ch3: only the falling edge is reported.
        do_reset();
        pos_en = 4'b0111;
        neg_en = 4'b1111;
        ready  = 1'b1;
        hs_log.delete();
        din = 4'b1000;
        tick();
        din = 4'b0000;
        repeat (10) tick();
        chk("mask_count", hs_log.size(), 1);
        if (hs_log.size() > 0) begin
            chk("mask_channel", hs_log[0].ch, 3);
            chk("mask_polarity", 32'(hs_log[0].pol), 0);
        end

        // Line held high across reset release, then reset while the slot is full.
        pos_en = '1;
        neg_en = '1;
        ready  = 1'b0;
        clear  = 1'b0;
        din    = 4'b0001;
        rst    = 1'b1;
        tick();
        tick();
        rst   = 1'b0;
        first = -1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (valid && first < 0) first = k;
        end
        chk("release_latency", first, 3 + EXTRA);
        chk("release_channel", 32'(ch), 0);
        chk("release_polarity", 32'(pol), 1);
        rst = 1'b1;
        din = '0;
        tick();
        chk("midreset_valid", 32'(valid), 0);
        rst   = 1'b0;
        ready = 1'b1;
        hs_log.delete();
        repeat (12) tick();
        chk("midreset_stale", hs_log.size(), 0);

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 49) == 0) begin
                pos_en = N'($urandom);
                neg_en = N'($urandom);
            end
            din   = din ^ (N'($urandom) & N'($urandom));
            ready = ($urandom_range(0, 3) != 0);
            clear = ($urandom_range(0, 15) == 0);
            rst   = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
